// File: rtl/router_sta.sv
// rtl/router_sta.sv - registered static XY/YX route computation for one 2x4 mesh router
// Address layout {Y, X[1:0]}; port holds NONE (3'b111) until the first enabled edge.
module router_sta #(
  parameter int ROUTE_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] router_add,
  input  logic [2:0] dst,
  output logic [2:0] port
);

  localparam logic [2:0] P_LOCAL = 3'b000;
  localparam logic [2:0] P_EAST  = 3'b001;
  localparam logic [2:0] P_WEST  = 3'b010;
  localparam logic [2:0] P_NORTH = 3'b011;
  localparam logic [2:0] P_SOUTH = 3'b100;
  localparam logic [2:0] P_NONE  = 3'b111;

  logic [1:0] w_cx;
  logic [1:0] w_dx;
  logic       w_cy;
  logic       w_dy;
  logic [2:0] w_x_port;
  logic [2:0] w_y_port;
  logic [2:0] w_route;
  logic [2:0] r_port;

  assign w_cx = router_add[1:0];
  assign w_cy = router_add[2];
  assign w_dx = dst[1:0];
  assign w_dy = dst[2];

  // Each dimension resolves to LOCAL when already aligned, so ordering is a simple fallthrough.
  always_comb begin
    w_x_port = P_LOCAL;
    if (w_dx > w_cx)
      w_x_port = P_EAST;
    else if (w_dx < w_cx)
      w_x_port = P_WEST;
  end

  always_comb begin
    w_y_port = P_LOCAL;
    if (w_dy > w_cy)
      w_y_port = P_SOUTH;
    else if (w_dy < w_cy)
      w_y_port = P_NORTH;
  end

  always_comb begin
    w_route = P_LOCAL;
    if (ROUTE_MODE == 0)
      w_route = (w_x_port != P_LOCAL) ? w_x_port : w_y_port;
    else
      w_route = (w_y_port != P_LOCAL) ? w_y_port : w_x_port;
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n)
      r_port <= P_NONE;
    else if (en)
      r_port <= w_route;
  end

  assign port = r_port;

endmodule

// File: tb/tb_router_sta.sv
// tb/tb_router_sta.sv - self-checking bench for router_sta, XY and YX instances side by side
module tb_router_sta;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] router_add;
  logic [2:0] dst;
  logic [2:0] port_xy;
  logic [2:0] port_yx;

  logic [2:0] exp_xy;
  logic [2:0] exp_yx;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  router_sta #(.ROUTE_MODE(0)) dut_xy (
    .clk(clk), .rst_n(rst_n), .en(en), .router_add(router_add), .dst(dst), .port(port_xy)
  );

  router_sta #(.ROUTE_MODE(1)) dut_yx (
    .clk(clk), .rst_n(rst_n), .en(en), .router_add(router_add), .dst(dst), .port(port_yx)
  );

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Signed displacement toward the destination; the leading dimension wins unless it is zero.
  function automatic logic [2:0] ref_route(input int mode, input logic [2:0] a, input logic [2:0] d);
    int ddx;
    int ddy;
    logic [2:0] xr;
    logic [2:0] yr;
    ddx = int'(d[1:0]) - int'(a[1:0]);
    ddy = int'(d[2]) - int'(a[2]);
    xr = (ddx > 0) ? 3'b001 : (ddx < 0) ? 3'b010 : 3'b000;
    yr = (ddy > 0) ? 3'b100 : (ddy < 0) ? 3'b011 : 3'b000;
    if (mode == 0) return (ddx != 0) ? xr : yr;
    return (ddy != 0) ? yr : xr;
  endfunction

  task automatic tick(input string tag, input logic r, input logic e,
                      input logic [2:0] a, input logic [2:0] d);
    rst_n = r;
    en = e;
    router_add = a;
    dst = d;
    @(posedge clk);
    if (r) begin
      exp_xy = 3'b111;
      exp_yx = 3'b111;
    end else if (e) begin
      exp_xy = ref_route(0, a, d);
      exp_yx = ref_route(1, a, d);
    end
    #1;
    check({tag, "_xy"}, port_xy, exp_xy);
    check({tag, "_yx"}, port_yx, exp_yx);
  endtask

  initial begin
    exp_xy = 3'b111;
    exp_yx = 3'b111;
    rst_n = 1'b1;
    en = 1'b0;
    router_add = 3'b000;
    dst = 3'b000;

    // T1 reset then idle with en low
    tick("rst0", 1'b1, 1'b0, 3'b000, 3'b000);
    tick("rst1", 1'b1, 1'b0, 3'b000, 3'b000);
    check("rst_none", port_xy, 3'b111);
    tick("idle0", 1'b0, 1'b0, 3'b010, 3'b101);
    tick("idle1", 1'b0, 1'b0, 3'b011, 3'b000);
    check("idle_none", port_xy, 3'b111);

    // T2 / T3 directed
    tick("t2_local", 1'b0, 1'b1, 3'b000, 3'b000);
    check("t2_local_lit", port_xy, 3'b000);
    tick("t2_east", 1'b0, 1'b1, 3'b000, 3'b011);
    check("t2_east_lit", port_xy, 3'b001);
    tick("t2_west", 1'b0, 1'b1, 3'b011, 3'b000);
    check("t2_west_lit", port_xy, 3'b010);
    tick("t3_south", 1'b0, 1'b1, 3'b001, 3'b101);
    check("t3_south_lit", port_xy, 3'b100);
    tick("t3_north", 1'b0, 1'b1, 3'b110, 3'b010);
    check("t3_north_lit", port_xy, 3'b011);
    tick("t3_local", 1'b0, 1'b1, 3'b101, 3'b101);
    check("t3_local_lit", port_xy, 3'b000);

    // T4 dimension order
    tick("t4", 1'b0, 1'b1, 3'b000, 3'b111);
    check("t4_xy_lit", port_xy, 3'b001);
    check("t4_yx_lit", port_yx, 3'b100);

    // T5 enable/hold
    tick("t5_load", 1'b0, 1'b1, 3'b000, 3'b011);
    check("t5_load_lit", port_xy, 3'b001);
    tick("t5_hold", 1'b0, 1'b0, 3'b000, 3'b100);
    check("t5_hold_lit", port_xy, 3'b001);
    tick("t5_en", 1'b0, 1'b1, 3'b000, 3'b100);
    check("t5_en_lit", port_xy, 3'b100);

    // T6 exhaustive sweep with a mid-sweep reset
    for (int i = 0; i < 64; i++) begin
      logic [5:0] pair;
      pair = 6'(i);
      tick("sweep", 1'b0, 1'b1, pair[5:3], pair[2:0]);
      check("sweep_legal_xy", {2'b00, (port_xy == 3'b101 || port_xy == 3'b110 || port_xy == 3'b111)}, 3'b000);
      check("sweep_legal_yx", {2'b00, (port_yx == 3'b101 || port_yx == 3'b110 || port_yx == 3'b111)}, 3'b000);
      if (i == 31) begin
        tick("sweep_rst", 1'b1, 1'b1, 3'b000, 3'b111);
        check("sweep_rst_lit", port_xy, 3'b111);
      end
    end

    // Randomized traffic with occasional reset and enable drops
    for (int i = 0; i < 300; i++) begin
      tick("rand", ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
